// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queued command issuer for RemoteComm.
// Commands are pushed into a circular FIFO and issued one at a time on
// send_cmd/cmd. Each entry then completes on an ACK response byte or on
// a falling edge of evt_n, followed by a fixed idle gap before the next issue.
// Status is reported through sticky done/err flags, err_code and cmd_idx.
// Optional feature: define CMD_SEQ_TIMEOUT_EN to bound the wait states
// to TIMEOUT_CYC cycles (err_code 2'b10 on expiry).
module cmd_sequencer #(
    parameter int unsigned       CMD_W       = 16,
    parameter int unsigned       RESP_W      = 8,
    parameter int unsigned       DEPTH       = 16,
    parameter logic [RESP_W-1:0] ACK_VAL     = 8'hA5,
    parameter int unsigned       GAP_CYC     = 4,
    parameter int unsigned       TIMEOUT_CYC = 2**24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_cmd,
    input  logic                       wr_wait_evt,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       start,
    input  logic                       abort,
    output logic                       send_cmd,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       resp_rdy,
    input  logic [RESP_W-1:0]          resp,
    input  logic                       evt_n,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH):0]     cmd_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = AW + 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_WAIT_EVT  = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    // FIFO storage: bit CMD_W holds the wait-for-event flag
    logic [CMD_W:0]    mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              full_r;
    logic [CMD_W:0]    head_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;

    logic              evt_prev_r;
    logic              evt_fall_s;
    logic [GW-1:0]     gap_cnt_r;
    logic              gap_last_s;
    logic              start_ok_s;
    logic              resp_ack_s;
    logic              cpl_s;
    logic              timeout_hit_s;
    logic              to_fire_s;

    logic              send_cmd_r;
    logic              send_cmd_s;
    logic [CMD_W-1:0]  cmd_r;
    logic [CMD_W-1:0]  cmd_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              err_r;
    logic              err_s;
    logic [1:0]        err_code_r;
    logic [1:0]        err_code_s;
    logic [IW-1:0]     cmd_idx_r;
    logic [IW-1:0]     cmd_idx_s;
    logic              first_r;
    logic              first_s;

    assign head_s       = mem_r[rd_ptr_r];
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    // a push into a full FIFO is dropped even when a pop happens this cycle
    assign push_s       = wr_en && !full_r && !abort;
    assign pop_s        = (state_r == ST_ISSUE) && !abort;
    assign evt_fall_s   = evt_prev_r && !evt_n;
    assign gap_last_s   = (gap_cnt_r == GW'(GAP_CYC - 1));
    assign resp_ack_s   = (resp == ACK_VAL);
    assign start_ok_s   = start && !abort &&
                          ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    // any response byte or event edge counts as completion and beats a timeout
    assign cpl_s        = ((state_r == ST_WAIT_RESP) && resp_rdy) ||
                          ((state_r == ST_WAIT_EVT) && evt_fall_s);
    assign to_fire_s    = timeout_hit_s && !cpl_s;

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_r;

    // wait-state cycle counter, zero whenever not waiting so each wait starts fresh
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if ((state_r == ST_WAIT_RESP) || (state_r == ST_WAIT_EVT)) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= {TW{1'b0}};
        end
    end

    assign timeout_hit_s = ((state_r == ST_WAIT_RESP) || (state_r == ST_WAIT_EVT)) &&
                           (to_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timeout_unused_s;

    assign timeout_unused_s = TW'(TIMEOUT_CYC);
    assign timeout_hit_s    = 1'b0;
`endif

    // occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers and occupancy; abort flushes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else if (abort) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // FIFO entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {wr_wait_evt, wr_cmd};
        end
    end

    // event history for edge detection and the inter-command gap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_prev_r <= 1'b1;
            gap_cnt_r  <= {GW{1'b0}};
        end else begin
            evt_prev_r <= evt_n;
            if ((state_r == ST_GAP) && !gap_last_s) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic; abort has priority over every other input
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            if (state_r != ST_IDLE) begin
                state_next_s = ST_ERR;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        if (fifo_empty_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_ISSUE;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_ISSUE: begin
                    if (head_s[CMD_W]) begin
                        state_next_s = ST_WAIT_EVT;
                    end else begin
                        state_next_s = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_rdy) begin
                        if (resp_ack_s) begin
                            state_next_s = ST_GAP;
                        end else begin
                            state_next_s = ST_ERR;
                        end
                    end else if (to_fire_s) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_EVT: begin
                    if (evt_fall_s) begin
                        state_next_s = ST_GAP;
                    end else if (to_fire_s) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_WAIT_EVT;
                    end
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        if (fifo_empty_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_ISSUE;
                        end
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // next values of the registered outputs
    always_comb begin
        send_cmd_s = 1'b0;
        cmd_s      = cmd_r;
        err_code_s = err_code_r;
        cmd_idx_s  = cmd_idx_r;
        first_s    = first_r;
        done_s     = (state_next_s == ST_DONE);
        err_s      = (state_next_s == ST_ERR);
        case (state_next_s)
            ST_ISSUE, ST_WAIT_RESP, ST_WAIT_EVT, ST_GAP: busy_s = 1'b1;
            default:                                      busy_s = 1'b0;
        endcase
        if (abort) begin
            if (state_r != ST_IDLE) begin
                err_code_s = 2'b11;
            end else begin
                err_code_s = err_code_r;
            end
        end else if (start_ok_s) begin
            err_code_s = 2'b00;
            cmd_idx_s  = {IW{1'b0}};
            first_s    = 1'b1;
        end else if (pop_s) begin
            send_cmd_s = 1'b1;
            cmd_s      = head_s[CMD_W-1:0];
            first_s    = 1'b0;
            // the first issue after start keeps index 0
            if (first_r) begin
                cmd_idx_s = cmd_idx_r;
            end else begin
                cmd_idx_s = cmd_idx_r + IW'(1);
            end
        end else if ((state_r == ST_WAIT_RESP) && resp_rdy && !resp_ack_s) begin
            err_code_s = 2'b01;
        end else if (to_fire_s) begin
            err_code_s = 2'b10;
        end else begin
            err_code_s = err_code_r;
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_cmd_r <= 1'b0;
            cmd_r      <= {CMD_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
            cmd_idx_r  <= {IW{1'b0}};
            first_r    <= 1'b0;
        end else begin
            send_cmd_r <= send_cmd_s;
            cmd_r      <= cmd_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            err_code_r <= err_code_s;
            cmd_idx_r  <= cmd_idx_s;
            first_r    <= first_s;
        end
    end

    assign full     = full_r;
    assign count    = count_r;
    assign send_cmd = send_cmd_r;
    assign cmd      = cmd_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;
    assign cmd_idx  = cmd_idx_r;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomised bench for cmd_sequencer against a transaction-level queue model.
module tb_cmd_sequencer;

    localparam int         CMD_W   = 16;
    localparam int         RESP_W  = 8;
    localparam int         DEPTH   = 16;
    localparam int         GAP_CYC = 4;
    localparam logic [7:0] ACK_VAL = 8'hA5;
`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`else
    localparam int TIMEOUT_CYC = 2**24;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [CMD_W-1:0]  wr_cmd = '0;
    logic              wr_wait_evt = 1'b0;
    logic              full;
    logic [4:0]        count;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              send_cmd;
    logic [CMD_W-1:0]  cmd;
    logic              resp_rdy = 1'b0;
    logic [RESP_W-1:0] resp = '0;
    logic              evt_n = 1'b1;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [4:0]        cmd_idx;

    always #5 clk = ~clk;

    cmd_sequencer #(
        .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .ACK_VAL(ACK_VAL),
        .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd),
        .wr_wait_evt(wr_wait_evt), .full(full), .count(count), .start(start),
        .abort(abort), .send_cmd(send_cmd), .cmd(cmd), .resp_rdy(resp_rdy),
        .resp(resp), .evt_n(evt_n), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .cmd_idx(cmd_idx)
    );

    typedef struct {
        logic [CMD_W-1:0] cmd;
        logic             evt;
    } ent_t;

    ent_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   ord_g   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_one(input ent_t e);
        wr_en = 1'b1; wr_cmd = e.cmd; wr_wait_evt = e.evt;
        tick();
        wr_en = 1'b0;
        if (q.size() < DEPTH) q.push_back(e);
    endtask

    task automatic flush_fifo();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        chk("flush_count", count, 0);
    endtask

    // one wait-state cycle with noise that must not complete the entry
    task automatic noise_tick(input logic evt_mode);
        ent_t e;
        logic do_push;
        e.cmd   = 16'($urandom);
        e.evt   = 1'($urandom_range(0, 1));
        do_push = ($urandom_range(0, 4) == 0) && (q.size() + ord_g < 28);
        wr_en = do_push; wr_cmd = e.cmd; wr_wait_evt = e.evt;
        start = ($urandom_range(0, 9) == 0);
        if (evt_mode) begin
            resp_rdy = 1'($urandom_range(0, 1));
            resp     = 8'($urandom);
        end else begin
            evt_n = 1'($urandom_range(0, 1));
        end
        tick();
        wr_en = 1'b0; start = 1'b0; resp_rdy = 1'b0;
        if (do_push && q.size() < DEPTH) q.push_back(e);
        chk("busy_in_wait", busy, 1);
        chk("no_err_in_wait", err, 0);
    endtask

    task automatic check_silent();
        int n = 0;
        repeat (8) begin
            tick();
            if (send_cmd) n++;
        end
        chk("no_issue_after_err", n, 0);
        chk("err_sticky", err, 1);
    endtask

    task automatic run_scenario(input int s);
        int   k, r, d, w, e_tick;
        ent_t e, cur;
        logic do_abort, do_bad;
        flush_fifo();
        if (s == 1) k = DEPTH + 1;
        else if (s == 2) k = 0;
        else k = $urandom_range(0, DEPTH + 2);
        for (int i = 0; i < k; i++) begin
            e.cmd = 16'($urandom);
            e.evt = 1'($urandom_range(0, 1));
            push_one(e);
        end
        chk("fill_count", count, q.size());
        chk("fill_full", full, (q.size() == DEPTH));
        evt_n = 1'($urandom_range(0, 1));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (q.size() == 0) begin
            chk("empty_done", done, 1);
            chk("empty_err", err, 0);
            chk("empty_code", err_code, 0);
            chk("empty_busy", busy, 0);
            return;
        end
        ord_g  = 0;
        e_tick = 0;
        while (1'b1) begin
            for (w = 0; w < GAP_CYC + 8; w++) begin
                if (send_cmd || done || err) break;
                tick();
            end
            chk("issue_seen", send_cmd, 1);
            if (!send_cmd) return;
            if (ord_g > 0)
                chk("issue_gap_ok", ((cyc - e_tick) >= GAP_CYC + 1) && ((cyc - e_tick) <= GAP_CYC + 2), 1);
            cur = q.pop_front();
            chk("issue_cmd", cmd, cur.cmd);
            chk("issue_idx", cmd_idx, ord_g & 31);
            chk("issue_count", count, q.size());
            chk("issue_err_clear", err, 0);
            chk("issue_code_clear", err_code, 0);
            tick();
            chk("send_pulse_width", send_cmd, 0);
            r        = $urandom_range(0, 99);
            do_abort = (r < 6);
            do_bad   = !cur.evt && (r >= 6) && (r < 18);
            d        = $urandom_range(0, 4);
            repeat (d) noise_tick(cur.evt);
            if (do_abort) begin
                abort = 1'b1; resp_rdy = 1'b1; resp = ACK_VAL; evt_n = 1'b0;
                tick();
                abort = 1'b0; resp_rdy = 1'b0;
                q.delete();
                chk("abort_err", err, 1);
                chk("abort_code", err_code, 3);
                chk("abort_count", count, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_idx", cmd_idx, ord_g & 31);
                check_silent();
                return;
            end
            if (!cur.evt) begin
                resp_rdy = 1'b1;
                resp     = do_bad ? (8'($urandom_range(0, 255)) ^ 8'h00) : ACK_VAL;
                if (do_bad && resp == ACK_VAL) resp = 8'h5A;
                tick();
                resp_rdy = 1'b0;
                e_tick   = cyc;
                if (do_bad) begin
                    chk("bad_err", err, 1);
                    chk("bad_code", err_code, 1);
                    chk("bad_done", done, 0);
                    chk("bad_busy", busy, 0);
                    chk("bad_idx", cmd_idx, ord_g & 31);
                    chk("bad_count", count, q.size());
                    check_silent();
                    return;
                end
            end else begin
                if (evt_n == 1'b0) begin
                    evt_n = 1'b1;
                    tick();
                    chk("no_cpl_on_rise", busy, 1);
                end
                evt_n = 1'b0;
                tick();
                e_tick = cyc;
            end
            ord_g++;
            if (q.size() == 0) begin
                for (w = 0; w < GAP_CYC + 4; w++) begin
                    if (done || send_cmd) break;
                    tick();
                end
                chk("done_set", done, 1);
                chk("done_delay_ok", ((cyc - e_tick) >= GAP_CYC) && ((cyc - e_tick) <= GAP_CYC + 1), 1);
                chk("done_err", err, 0);
                chk("done_code", err_code, 0);
                chk("done_busy", busy, 0);
                chk("done_count", count, 0);
                chk("done_idx", cmd_idx, (ord_g - 1) & 31);
                return;
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_send", send_cmd, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_idx", cmd_idx, 0);
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 40; s++) run_scenario(s);
`ifdef CMD_SEQ_TIMEOUT_EN
        begin
            ent_t e;
            int   w;
            flush_fifo();
            e.cmd = 16'h1234;
            e.evt = 1'b0;
            push_one(e);
            evt_n = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (w = 0; w < 10; w++) begin
                if (send_cmd) break;
                tick();
            end
            chk("to_issue", send_cmd, 1);
            repeat (TIMEOUT_CYC - 1) tick();
            chk("to_not_early", err, 0);
            tick();
            chk("to_err", err, 1);
            chk("to_code", err_code, 2);
        end
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Parametrised hardware command sequencer that replaces hand-written send/wait/check sequences for MazeRunner. Commands are queued into an internal FIFO, then issued one at a time to RemoteComm's send_cmd/cmd interface. Each entry completes on either a response byte (checked against ACK_VAL) or a falling edge on an event input such as hall_n. Sits beside RemoteComm in benches and FPGA self-test tops; reports done/error status and the index of the failing command.

Parameters:
CMD_W, 16, command width
RESP_W, 8, response width
DEPTH, 16, FIFO entries (power of 2, >=2)
ACK_VAL, 8'hA5, expected positive acknowledge
GAP_CYC, 4, idle cycles between response/event and next issue (>=1)
TIMEOUT_CYC, 2**24, wait-state cycle limit (TIMEOUT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  push {wr_wait_evt, wr_cmd} into FIFO
wr_cmd  in  CMD_W  command to queue
wr_wait_evt  in  1  1 = entry completes on evt_n falling edge; 0 = completes on resp_rdy
full  out  1  FIFO full
count  out  $clog2(DEPTH+1)  FIFO occupancy
start  in  1  begin issuing queued commands
abort  in  1  stop sequence and flush FIFO
send_cmd  out  1  one-cycle pulse to RemoteComm
cmd  out  CMD_W  command to RemoteComm, held between issues
resp_rdy  in  1  response byte valid from RemoteComm
resp  in  RESP_W  response byte
evt_n  in  1  active-low event (e.g. hall_n)
busy  out  1  sequence in progress
done  out  1  sticky: all entries completed OK
err  out  1  sticky: sequence failed
err_code  out  2  00 none, 01 bad resp, 10 timeout, 11 abort
cmd_idx  out  $clog2(DEPTH)+1  ordinal of last issued command (0-based), for error reporting

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n. On reset: FIFO empty, count=0, full=0, send_cmd=0, cmd=0, busy=0, done=0, err=0, err_code=00, cmd_idx=0, evt_n history=1, state=IDLE.
- FIFO: circular read/write pointers. A push when full is dropped, even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves count unchanged. Pushes are accepted in every state.
- FSM states: IDLE, ISSUE, WAIT_RESP, WAIT_EVT, GAP, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Clears done, err, err_code and cmd_idx.
  - FIFO empty: go to DONE with done=1 the next cycle.
  - FIFO not empty: go to ISSUE.
  - start while busy is ignored.
- ISSUE (1 cycle):
  - Pops the head entry, drives cmd, and pulses send_cmd=1 for exactly this cycle. send_cmd is registered, so it is visible one cycle after entering ISSUE.
  - Latches the entry's wait_evt bit.
  - Increments cmd_idx, except on the first issue after start.
  - Goes to WAIT_EVT if wait_evt=1, otherwise WAIT_RESP.
- WAIT_RESP:
  - resp_rdy with resp==ACK_VAL: go to GAP.
  - resp_rdy with resp!=ACK_VAL: go to ERR, err_code=01.
- WAIT_EVT:
  - Completes on a falling edge of evt_n (previous sample 1, current 0). Goes to GAP.
  - resp_rdy is ignored in this state.
  - An evt_n that is already low on entry does not complete the entry.
- GAP: counts GAP_CYC cycles. Then goes to ISSUE if the FIFO is not empty, otherwise to DONE (done=1).
- abort in any non-IDLE state: go to ERR, err_code=11, flush FIFO. abort in IDLE only flushes the FIFO.
- abort wins over resp_rdy, evt_n and start in the same cycle.
- busy=1 in ISSUE, WAIT_RESP, WAIT_EVT and GAP.
- done and err are mutually exclusive and hold until the next start or reset.

Optional Feature:
CMD_SEQ_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_RESP or WAIT_EVT. If TIMEOUT_CYC cycles elapse without completion, go to ERR with err_code=10. A completion arriving on the same cycle as expiry wins over the timeout.
- Undefined: the wait states block indefinitely, the counter is absent, and err_code 10 is never produced.

Test Plan:
- Queue 16'h0000 (resp mode), start, return resp=8'hA5 after 100 cycles -> exactly one send_cmd pulse with cmd=16'h0000; done=1 GAP_CYC cycles later; err=0.
- Queue 0x4000, 0x23FF, 0x4000 (resp mode), ack each with A5 -> three send_cmd pulses in order, each at least GAP_CYC+1 cycles after the previous ack; cmd_idx=2; done=1.
- Queue 0x0000, 0x4000; respond 8'h5A to the first -> err=1, err_code=01, cmd_idx=0, count=1, no second send_cmd.
- Queue 0x6000 with wait_evt=1; hold evt_n low at issue, raise it, then drop it -> completion only on the 1->0 edge; done=1; resp_rdy pulses during the wait are ignored.
- Fill DEPTH+1 entries -> full=1, count=DEPTH, last entry dropped. Assert abort mid-WAIT_RESP -> err_code=11, count=0, busy=0.
- With CMD_SEQ_TIMEOUT_EN and TIMEOUT_CYC=50, issue a command with no response -> err=1, err_code=10 exactly 50 cycles after WAIT_RESP entry.
